// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron trainer's sample path.
// Targets use the same 2-bit signed encoding as the trainer's y_sign.
package neuron_pkg;

  localparam int NEURON_DATA_W = 14;

  localparam logic [1:0] T_POS = 2'b01;
  localparam logic [1:0] T_NEG = 2'b11;

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    REPLAY
  } state_t;

  typedef struct packed {
    logic signed [NEURON_DATA_W-1:0] x1;
    logic signed [NEURON_DATA_W-1:0] x2;
    logic [1:0]                      t;
  } sample_t;

  function automatic logic t_is_valid(input logic [1:0] t);
    return (t == T_POS) || (t == T_NEG);
  endfunction

endpackage

// File: rtl/neuron_sample_store_if.sv
// Host write port plus trainer replay port of the sample store.
// The host/trainer side uses master; the store itself uses slave.
interface neuron_sample_store_if #(
  parameter int DATA_W = neuron_pkg::NEURON_DATA_W,
  parameter int ADDR_W = 6
);
  logic                     clear;
  logic                     wr_en;
  logic signed [DATA_W-1:0] wr_x1;
  logic signed [DATA_W-1:0] wr_x2;
  logic [1:0]               wr_t;
  logic                     full;
  logic [ADDR_W:0]          count;
  logic                     init;
  logic                     next;
  logic signed [DATA_W-1:0] x1;
  logic signed [DATA_W-1:0] x2;
  logic [1:0]               t;
  logic                     eof;
  logic                     err;

  modport master (
    output clear, wr_en, wr_x1, wr_x2, wr_t, init, next,
    input  full, count, x1, x2, t, eof, err
  );

  modport slave (
    input  clear, wr_en, wr_x1, wr_x2, wr_t, init, next,
    output full, count, x1, x2, t, eof, err
  );
endinterface

// File: rtl/sample_ram.sv
// Single-write, single synchronous-read sample storage with no reset.
// A read of the address being written returns the new word (write-first).
module sample_ram #(
  parameter int WIDTH  = 30,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/neuron_sample_store.sv
// Training-sample buffer: host loads samples, trainer replays them one per
// next pulse and rewinds on init at each epoch; eof marks end of a pass.
module neuron_sample_store
  import neuron_pkg::*;
#(
  parameter int DATA_W = NEURON_DATA_W,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input logic                  clk,
  input logic                  rst,
  neuron_sample_store_if.slave bus
);

  localparam int              SAMPLE_W = 2 * DATA_W + 2;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);

  state_t          state_reg, state_next;
  logic [ADDR_W:0] count_reg, count_next;
  logic [ADDR_W:0] rd_ptr_reg, rd_ptr_next;
  logic            err_reg, err_next;
  logic            eof_reg;
  logic            valid_reg;

  logic                full;
  logic                at_end;
  logic                wr_accept;
  logic [SAMPLE_W-1:0] wr_word;
  logic [SAMPLE_W-1:0] rd_word;

  assign full      = (count_reg == DEPTH_C);
  assign at_end    = (state_reg == REPLAY) && (rd_ptr_reg == count_reg);
  assign wr_accept = bus.wr_en && !bus.clear && !full;
  assign wr_word   = {bus.wr_x1, bus.wr_x2, bus.wr_t};

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    err_next    = err_reg;
    if (bus.clear) begin
      state_next  = EMPTY;
      count_next  = '0;
      rd_ptr_next = '0;
      err_next    = 1'b0;
    end else begin
      if (bus.wr_en) begin
        if (full || !t_is_valid(bus.wr_t)) begin
          err_next = 1'b1;
        end
        if (!full) begin
          count_next = count_reg + 1'b1;
          if (state_reg == EMPTY) begin
            state_next = LOAD;
          end
        end
      end
      if (bus.init) begin
        state_next  = REPLAY;
        rd_ptr_next = '0;
      end else if (state_reg == REPLAY) begin
        // A finished pass stays finished: an append at eof drags the pointer along.
        if (bus.next && !at_end) begin
          rd_ptr_next = rd_ptr_reg + 1'b1;
        end else if (at_end && wr_accept) begin
          rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        if (bus.next && at_end) begin
          err_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= EMPTY;
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      err_reg    <= 1'b0;
      eof_reg    <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      err_reg    <= err_next;
      eof_reg    <= (state_next == REPLAY) && (rd_ptr_next == count_next);
      valid_reg  <= (state_next == REPLAY) && (rd_ptr_next != count_next);
    end
  end

  // The read address is the upcoming pointer so data lands one cycle after next/init.
  sample_ram #(
    .WIDTH  (SAMPLE_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_sample_ram (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (count_reg[ADDR_W-1:0]),
    .wdata (wr_word),
    .raddr (rd_ptr_next[ADDR_W-1:0]),
    .rdata (rd_word)
  );

  assign bus.x1    = valid_reg ? rd_word[SAMPLE_W-1 -: DATA_W] : '0;
  assign bus.x2    = valid_reg ? rd_word[DATA_W+1 -: DATA_W]   : '0;
  assign bus.t     = valid_reg ? rd_word[1:0]                  : 2'b00;
  assign bus.eof   = eof_reg;
  assign bus.err   = err_reg;
  assign bus.full  = full;
  assign bus.count = count_reg;

endmodule
